node_tree_walker: RTL

Parametrised successor to the fixed-tree node lookup. It holds a writable node table and a stack of node pointers, so nested messages can be entered and left. The block resolves each incoming field identifier against the children of the current node, emits the matched node data, and descends into or ascends out of sub-trees. It sits between the field-id tokeniser and the node consumer.

---
 rtl/node_tree_walker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/node_tree_walker.sv
// node_tree_walker: resolves field ids against the children of the current node in a writable tree table,
// descending into and ascending out of sub-trees via a pointer stack.
module node_tree_walker #(
  parameter int ID_W = 8,
  parameter int DATA_W = 16,
  parameter int NUM_NODES = 64,
  parameter int MAX_CHILDREN = 8,
  parameter int MAX_DEPTH = 8,
  localparam int IDX_W = $clog2(NUM_NODES),
  localparam int CNT_W = $clog2(MAX_CHILDREN + 1),
  localparam int DEP_W = $clog2(MAX_DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ID_W-1:0]   field_id_i,
  input  logic              op_i,
  input  logic              field_id_valid_i,
  output logic              field_id_rdy_o,
  output logic              node_valid_o,
  input  logic              node_rdy_i,
  output logic [DATA_W-1:0] node_o,
  output logic [IDX_W-1:0]  node_idx_o,
  output logic [DEP_W-1:0]  depth_o,
  output logic [1:0]        err_o,
  input  logic              tree_restart_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_addr_i,
  input  logic [ID_W-1:0]   cfg_id_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic [IDX_W-1:0]  cfg_first_child_i,
  input  logic [CNT_W-1:0]  cfg_child_cnt_i,
  output logic              cfg_rdy_o
);
  localparam int E_W = ID_W + DATA_W + IDX_W + CNT_W;
  typedef enum logic [1:0] {IDLE, SCAN, ASC, RESP} state_t;
  state_t state;
  logic [E_W-1:0] mem [NUM_NODES];
  logic [E_W-1:0] rd_q;
  logic [IDX_W-1:0] stk [MAX_DEPTH];
  logic [IDX_W-1:0] rd_addr, ptr, cur, par;
  logic [CNT_W-1:0] rem;
  logic [DEP_W-1:0] depth;
  logic [ID_W-1:0] fid;
  logic first, top, hit, nf, ovf;
  logic [ID_W-1:0] rd_id;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0] rd_fc;
  logic [CNT_W-1:0] rd_cnt;
  assign {rd_id, rd_data, rd_fc, rd_cnt} = rd_q;
  assign cur = stk[depth];
  assign par = stk[depth - DEP_W'(depth != '0)];
  assign top = depth == DEP_W'(MAX_DEPTH - 1);
  assign hit = rd_id == fid;
  assign ovf = rd_cnt != '0 && top;
  // first SCAN cycle holds the current node's header; later cycles hold child ptr
  assign nf = first ? rd_cnt == '0 : !hit && rem == CNT_W'(1);
  assign field_id_rdy_o = state == IDLE;
  assign cfg_rdy_o = state == IDLE;
  always_comb
    rd_addr = state == IDLE ? (op_i ? par : cur) : (first ? rd_fc : ptr + 1'b1);
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && cfg_rdy_o)
      mem[cfg_addr_i] <= {cfg_id_i, cfg_data_i, cfg_first_child_i, cfg_child_cnt_i};
    rd_q <= mem[rd_addr];
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      first <= 1'b0;
      fid <= '0;
      ptr <= '0;
      rem <= '0;
      depth <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) stk[i] <= '0;
      node_valid_o <= 1'b0;
      node_o <= '0;
      node_idx_o <= '0;
      depth_o <= '0;
      err_o <= '0;
    end else if (tree_restart_i) begin
      state <= IDLE;
      depth <= '0;
      node_valid_o <= 1'b0;
      node_o <= '0;
      node_idx_o <= '0;
      depth_o <= '0;
      err_o <= '0;
    end else begin
      case (state)
        IDLE: if (field_id_valid_i) begin
          fid <= field_id_i;
          first <= 1'b1;
          state <= op_i ? ASC : SCAN;
        end
        SCAN: begin
          first <= 1'b0;
          ptr <= first ? rd_fc : ptr + 1'b1;
          rem <= first ? rd_cnt : rem - 1'b1;
          if (nf || (!first && hit)) begin
            state <= RESP;
            node_valid_o <= 1'b1;
            node_o <= nf ? '0 : rd_data;
            node_idx_o <= nf ? cur : ptr;
            err_o <= nf ? 2'd1 : ovf ? 2'd2 : 2'd0;
            depth_o <= depth + DEP_W'(!nf && rd_cnt != '0 && !top);
          end
        end
        ASC: begin
          state <= RESP;
          node_valid_o <= 1'b1;
          node_o <= rd_data;
          node_idx_o <= par;
          err_o <= depth == '0 ? 2'd3 : 2'd0;
          depth_o <= depth - DEP_W'(depth != '0);
        end
        RESP: if (node_rdy_i) begin
          state <= IDLE;
          node_valid_o <= 1'b0;
          if (depth_o > depth) stk[depth_o] <= node_idx_o;
          depth <= depth_o;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
